// File: rtl/sap1_prog_loader.sv
// Program loader for SAP-1: streams an image into the 16x8 program RAM, runs the core to HLT,
// and reports result/cycles/errors. Define SAP1_LOADER_ZFILL_EN to zero-fill unloaded addresses.
module sap1_prog_loader #(
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned CYC_W      = 16,
  parameter int unsigned MAX_CYCLES = 4000
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             ram_we,
  output logic [3:0]       ram_addr,
  output logic [7:0]       ram_wdata,
  output logic             cpu_clr,
  input  logic             cpu_hlt,
  input  logic [7:0]       cpu_out,
  output logic             busy,
  output logic             done,
  output logic [7:0]       result,
  output logic [CYC_W-1:0] cycles,
  output logic             err_overflow,
  output logic             err_timeout
);

  localparam int unsigned      ClrW    = $clog2(CLR_CYCLES + 1);
  localparam logic [ClrW-1:0]  ClrLast = ClrW'(CLR_CYCLES);
  localparam logic [CYC_W-1:0] CycMax  = CYC_W'(MAX_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDrain,
`ifdef SAP1_LOADER_ZFILL_EN
    StFill,
`endif
    StRelease,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       ptr_q, ptr_d;
  logic [4:0]       ptr_inc;
  logic             ram_we_q, ram_we_d;
  logic [3:0]       ram_addr_q, ram_addr_d;
  logic [7:0]       ram_wdata_q, ram_wdata_d;
  logic             cpu_clr_q, cpu_clr_d;
  logic [ClrW-1:0]  clr_cnt_q, clr_cnt_d;
  logic [7:0]       result_q, result_d;
  logic [CYC_W-1:0] cycles_q, cycles_d;
  logic [CYC_W-1:0] cyc_inc;
  logic             err_ovf_q, err_ovf_d;
  logic             err_to_q, err_to_d;
  logic             accept;
  state_e           img_end_state;

  assign in_ready = (state_q == StLoad) || (state_q == StDrain);
  assign accept   = in_valid & in_ready;
  assign ptr_inc  = ptr_q + 5'd1;
  assign cyc_inc  = cycles_q + 1'b1;

  // Where to go once the final image byte has been accepted in LOAD.
`ifdef SAP1_LOADER_ZFILL_EN
  assign img_end_state = ptr_inc[4] ? StRelease : StFill;
`else
  assign img_end_state = StRelease;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    clr_cnt_d   = '0;
    result_d    = result_q;
    cycles_d    = cycles_q;
    err_ovf_d   = err_ovf_q;
    err_to_d    = err_to_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StLoad;
          ptr_d     = '0;
          result_d  = '0;
          cycles_d  = '0;
          err_ovf_d = 1'b0;
          err_to_d  = 1'b0;
        end
      end

      StLoad: begin
        if (accept) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = ptr_q[3:0];
          ram_wdata_d = in_data;
          ptr_d       = ptr_inc;
          if (in_last) begin
            state_d = img_end_state;
          end else if (ptr_inc[4]) begin
            // 16 bytes taken and more are coming: the image cannot fit.
            state_d   = StDrain;
            err_ovf_d = 1'b1;
          end
        end
      end

      StDrain: begin
        if (accept && in_last) begin
          state_d = StRelease;
        end
      end

`ifdef SAP1_LOADER_ZFILL_EN
      StFill: begin
        ram_we_d    = 1'b1;
        ram_addr_d  = ptr_q[3:0];
        ram_wdata_d = 8'h00;
        ptr_d       = ptr_inc;
        if (ptr_q[3:0] == 4'hF) begin
          state_d = StRelease;
        end
      end
`endif

      StRelease: begin
        // First cycle carries the trailing registered write; CLR_CYCLES more follow with clear held.
        if (clr_cnt_q == ClrLast) begin
          state_d  = StRun;
          cycles_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      StRun: begin
        cycles_d = cyc_inc;
        if (cpu_hlt) begin
          result_d = cpu_out;
          state_d  = StDone;
        end else if (cyc_inc == CycMax) begin
          err_to_d = 1'b1;
          state_d  = StDone;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    cpu_clr_d = (state_d != StRun);
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      cpu_clr_q   <= 1'b1;
      clr_cnt_q   <= '0;
      result_q    <= '0;
      cycles_q    <= '0;
      err_ovf_q   <= 1'b0;
      err_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_clr_q   <= cpu_clr_d;
      clr_cnt_q   <= clr_cnt_d;
      result_q    <= result_d;
      cycles_q    <= cycles_d;
      err_ovf_q   <= err_ovf_d;
      err_to_q    <= err_to_d;
    end
  end

  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign cpu_clr      = cpu_clr_q;
  assign busy         = (state_q != StIdle) && (state_q != StDone);
  assign done         = (state_q == StDone);
  assign result       = result_q;
  assign cycles       = cycles_q;
  assign err_overflow = err_ovf_q;
  assign err_timeout  = err_to_q;

endmodule
